// File: rtl/uart_bus_bridge_pkg.sv
// Shared constants and state encoding for the UART-to-bus debug bridge.
package uart_bus_bridge_pkg;

  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] OP_RD   = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StWdata,
    StBusWr,
    StBusRd,
    StRdWait,
    StResp,
    StTxSend,
    StTxWait
  } bridge_state_e;

endpackage

// File: rtl/uart_bridge_resp_tx.sv
// Response shift buffer: emits len bytes MSB first, one per transmitter-idle window.
module uart_bridge_resp_tx
  import uart_bus_bridge_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [2:0]  len_i,
  input  logic [39:0] data_i,
  input  logic        tx_busy_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  output logic        done_o
);

  bridge_state_e st_q, st_d;
  logic [39:0]   shift_q, shift_d;
  logic [2:0]    left_q, left_d;
  logic          guard_q, guard_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q    <= StIdle;
      shift_q <= '0;
      left_q  <= '0;
      guard_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      shift_q <= shift_d;
      left_q  <= left_d;
      guard_q <= guard_d;
    end
  end

  always_comb begin
    st_d       = st_q;
    shift_d    = shift_q;
    left_d     = left_q;
    guard_d    = guard_q;
    tx_valid_o = 1'b0;
    tx_data_o  = 8'h00;
    done_o     = 1'b0;
    case (st_q)
      StIdle: begin
        if (load_i) begin
          shift_d = data_i;
          left_d  = len_i;
          st_d    = StTxSend;
        end
      end
      StTxSend: begin
        if (!tx_busy_i) begin
          tx_valid_o = 1'b1;
          tx_data_o  = shift_q[39:32];
          shift_d    = {shift_q[31:0], 8'h00};
          left_d     = left_q - 3'd1;
          guard_d    = 1'b0;
          st_d       = StTxWait;
        end
      end
      StTxWait: begin
        // First cycle is a blind guard so a late-rising tx_busy_i is not missed.
        if (!guard_q) begin
          guard_d = 1'b1;
        end else if (!tx_busy_i) begin
          if (left_q != 3'd0) begin
            st_d = StTxSend;
          end else begin
            done_o = 1'b1;
            st_d   = StIdle;
          end
        end
      end
      default: st_d = StIdle;
    endcase
  end

endmodule

// File: rtl/uart_bus_bridge.sv
// UART command-frame decoder acting as a single-beat 32-bit bus master.
module uart_bus_bridge
  import uart_bus_bridge_pkg::*;
#(
  parameter int unsigned FRAME_TIMEOUT = 200000,
  parameter int unsigned RD_TIMEOUT    = 1024
) (
  input  logic        clk_50m_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_8b_i,
  input  logic        rx_valid_i,
  output logic [7:0]  tx_data_8b_o,
  output logic        tx_valid_o,
  input  logic        tx_busy_i,
  output logic [31:0] addr_32b_o,
  output logic        wren_o,
  output logic        rden_o,
  output logic [31:0] din_32b_o,
  input  logic [31:0] dout_32b_i,
  input  logic        dout_32b_valid_i,
  output logic        bridge_busy_o,
  output logic [7:0]  drop_cnt_8b_o
);

  localparam int unsigned FtW = $clog2(FRAME_TIMEOUT + 1);
  localparam int unsigned RtW = $clog2(RD_TIMEOUT + 1);

  bridge_state_e state_q, state_d;
  logic          is_rd_q, is_rd_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [31:0]   addr_sh_q, addr_sh_d, data_sh_q, data_sh_d;
  logic [31:0]   addr_q, addr_d, din_q, din_d, rdata_q, rdata_d;
  logic          rsp_err_q, rsp_err_d;
  logic [FtW-1:0] ft_q, ft_d;
  logic [RtW-1:0] rt_q, rt_d;
  logic [7:0]    drop_q, drop_d;
  logic          frame_to, drop_inc;
  logic          resp_load, resp_done;
  logic [2:0]    resp_len;
  logic [39:0]   resp_data;

  always_ff @(posedge clk_50m_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      is_rd_q   <= 1'b0;
      cnt_q     <= '0;
      addr_sh_q <= '0;
      data_sh_q <= '0;
      addr_q    <= '0;
      din_q     <= '0;
      rdata_q   <= '0;
      rsp_err_q <= 1'b0;
      ft_q      <= '0;
      rt_q      <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      is_rd_q   <= is_rd_d;
      cnt_q     <= cnt_d;
      addr_sh_q <= addr_sh_d;
      data_sh_q <= data_sh_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      rdata_q   <= rdata_d;
      rsp_err_q <= rsp_err_d;
      ft_q      <= ft_d;
      rt_q      <= rt_d;
      drop_q    <= drop_d;
    end
  end

  assign frame_to = (ft_q == FtW'(FRAME_TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    is_rd_d   = is_rd_q;
    cnt_d     = cnt_q;
    addr_sh_d = addr_sh_q;
    data_sh_d = data_sh_q;
    addr_d    = addr_q;
    din_d     = din_q;
    rdata_d   = rdata_q;
    rsp_err_d = rsp_err_q;
    ft_d      = ft_q;
    rt_d      = rt_q;
    drop_d    = drop_q;
    drop_inc  = 1'b0;
    wren_o    = 1'b0;
    rden_o    = 1'b0;
    resp_load = 1'b0;
    case (state_q)
      StIdle: begin
        if (rx_valid_i) begin
          if (rx_data_8b_i == OP_WR || rx_data_8b_i == OP_RD) begin
            is_rd_d = (rx_data_8b_i == OP_RD);
            cnt_d   = '0;
            ft_d    = '0;
            state_d = StAddr;
          end else begin
            rsp_err_d = 1'b1;
            state_d   = StResp;
          end
        end
      end
      StAddr, StWdata: begin
        // Fields assemble in shadow registers so a timed-out frame leaves the bus outputs intact.
        if (frame_to) begin
          drop_inc = rx_valid_i;
          state_d  = StIdle;
        end else if (rx_valid_i) begin
          ft_d  = '0;
          cnt_d = cnt_q + 2'd1;
          if (state_q == StAddr) begin
            addr_sh_d = {addr_sh_q[23:0], rx_data_8b_i};
            if (cnt_q == 2'd3) begin
              if (is_rd_q) begin
                addr_d  = {addr_sh_q[23:0], rx_data_8b_i};
                state_d = StBusRd;
              end else begin
                state_d = StWdata;
              end
            end
          end else begin
            data_sh_d = {data_sh_q[23:0], rx_data_8b_i};
            if (cnt_q == 2'd3) begin
              addr_d  = addr_sh_q;
              din_d   = {data_sh_q[23:0], rx_data_8b_i};
              state_d = StBusWr;
            end
          end
        end else begin
          ft_d = ft_q + FtW'(1);
        end
      end
      StBusWr: begin
        wren_o    = 1'b1;
        rsp_err_d = 1'b0;
        state_d   = StResp;
      end
      StBusRd: begin
        rden_o  = 1'b1;
        rt_d    = '0;
        state_d = StRdWait;
      end
      StRdWait: begin
        if (dout_32b_valid_i) begin
          rdata_d   = dout_32b_i;
          rsp_err_d = 1'b0;
          state_d   = StResp;
        end else if (rt_q == RtW'(RD_TIMEOUT - 1)) begin
          rsp_err_d = 1'b1;
          state_d   = StResp;
        end else begin
          rt_d = rt_q + RtW'(1);
        end
      end
      StResp: begin
        resp_load = 1'b1;
        state_d   = StTxSend;
      end
      StTxSend, StTxWait: begin
        if (resp_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (rx_valid_i && !(state_q inside {StIdle, StAddr, StWdata})) drop_inc = 1'b1;
    if (drop_inc && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  assign resp_len  = (!rsp_err_q && is_rd_q) ? 3'd5 : 3'd1;
  assign resp_data = rsp_err_q ? {RSP_ERR, 32'h0} : {RSP_OK, rdata_q};

  uart_bridge_resp_tx u_resp_tx (
    .clk_i      (clk_50m_i),
    .rst_i      (rst_i),
    .load_i     (resp_load),
    .len_i      (resp_len),
    .data_i     (resp_data),
    .tx_busy_i  (tx_busy_i),
    .tx_data_o  (tx_data_8b_o),
    .tx_valid_o (tx_valid_o),
    .done_o     (resp_done)
  );

  assign addr_32b_o    = addr_q;
  assign din_32b_o     = din_q;
  assign drop_cnt_8b_o = drop_q;
  assign bridge_busy_o = (state_q != StIdle);

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Self-checking bench: table and random frames against a frame-level model plus corner sequences.
module tb_uart_bus_bridge;

  localparam int unsigned FT = 300;
  localparam int unsigned RT = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_busy;
  logic [31:0] addr;
  logic        wren;
  logic        rden;
  logic [31:0] din;
  logic [31:0] dout;
  logic        dout_valid;
  logic        bridge_busy;
  logic [7:0]  drop_cnt;

  initial forever #5 clk = ~clk;

  uart_bus_bridge #(.FRAME_TIMEOUT(FT), .RD_TIMEOUT(RT)) dut (
    .clk_50m_i        (clk),
    .rst_i            (rst),
    .rx_data_8b_i     (rx_data),
    .rx_valid_i       (rx_valid),
    .tx_data_8b_o     (tx_data),
    .tx_valid_o       (tx_valid),
    .tx_busy_i        (tx_busy),
    .addr_32b_o       (addr),
    .wren_o           (wren),
    .rden_o           (rden),
    .din_32b_o        (din),
    .dout_32b_i       (dout),
    .dout_32b_valid_i (dout_valid),
    .bridge_busy_o    (bridge_busy),
    .drop_cnt_8b_o    (drop_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitors, transmitter busy model and bus responder, all on the falling edge.
  int          cyc = 0;
  logic [7:0]  tx_q[$];
  int          tx_cyc[$];
  logic [31:0] wr_addr_q[$], wr_data_q[$], rd_addr_q[$];
  int          wr_cyc[$], rd_cyc[$];
  int          viol = 0;
  logic [31:0] bus_mem[logic [31:0]];
  logic [31:0] model_mem[logic [31:0]];
  int          rsp_delay = 3;
  int          rsp_cd = 0;
  logic [31:0] rsp_addr = '0;
  int          busy_len = 4;
  int          busy_cd = 0;
  bit          busy_arm = 0;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  initial forever @(posedge clk) cyc++;

  initial begin
    tx_busy    = 1'b0;
    dout       = '0;
    dout_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_valid) begin
        if (tx_busy) viol++;
        tx_q.push_back(tx_data);
        tx_cyc.push_back(cyc);
      end
      if (busy_cd > 0) begin
        busy_cd--;
        if (busy_cd == 0) tx_busy = 1'b0;
      end
      if (busy_arm) begin
        busy_arm = 0;
        tx_busy  = 1'b1;
        busy_cd  = busy_len;
      end
      if (tx_valid) busy_arm = 1;

      dout_valid = 1'b0;
      if (rsp_cd > 0) begin
        rsp_cd--;
        if (rsp_cd == 0) begin
          dout_valid = 1'b1;
          dout = bus_mem.exists(rsp_addr) ? bus_mem[rsp_addr] : dflt(rsp_addr);
        end
      end
      if (wren) begin
        wr_addr_q.push_back(addr);
        wr_data_q.push_back(din);
        wr_cyc.push_back(cyc);
        bus_mem[addr] = din;
      end
      if (rden) begin
        rd_addr_q.push_back(addr);
        rd_cyc.push_back(cyc);
        if (rsp_delay > 0) begin
          rsp_cd   = rsp_delay;
          rsp_addr = addr;
        end
      end
    end
  end

  task automatic clear_mon();
    tx_q.delete(); tx_cyc.delete();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc.delete();
    rd_addr_q.delete(); rd_cyc.delete();
  endtask

  task automatic send_bytes(input logic [7:0] b[$], input int gap, output int t_last);
    t_last = 0;
    foreach (b[i]) begin
      @(negedge clk);
      rx_data  = b[i];
      rx_valid = 1'b1;
      t_last   = cyc;
      repeat (gap) begin
        @(negedge clk);
        rx_valid = 1'b0;
      end
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((bridge_busy || tx_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_idle"}, bridge_busy, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_resp(input string name, input logic [7:0] exp[$]);
    chk({name, "_txlen"}, tx_q.size(), exp.size());
    foreach (exp[i])
      chk($sformatf("%s_tx%0d", name, i), (i < tx_q.size()) ? tx_q[i] : 8'hxx, exp[i]);
  endtask

  // Expected response built from the frame rules: 4B after a write, 4B + stored word after a read.
  task automatic run_frame(input string name, input logic is_rd, input logic [31:0] a,
                           input logic [31:0] d, input int gap, input logic [7:0] exp_code,
                           input int exp_len);
    logic [7:0]  b[$];
    logic [7:0]  exp[$];
    logic [31:0] v;
    logic [7:0]  drop0;
    int          t;
    clear_mon();
    drop0 = drop_cnt;
    b.push_back(is_rd ? 8'h52 : 8'h57);
    for (int i = 3; i >= 0; i--) b.push_back(a[8*i +: 8]);
    if (!is_rd) for (int i = 3; i >= 0; i--) b.push_back(d[8*i +: 8]);
    send_bytes(b, gap, t);
    wait_idle(name, 3000);
    exp.push_back(exp_code);
    if (is_rd) begin
      v = model_mem.exists(a) ? model_mem[a] : dflt(a);
      for (int i = 3; i >= 0; i--) exp.push_back(v[8*i +: 8]);
      chk({name, "_rdcnt"}, rd_addr_q.size(), 1);
      chk({name, "_rdaddr"}, (rd_addr_q.size() > 0) ? rd_addr_q[0] : 32'hx, a);
      chk({name, "_rdcyc"}, (rd_cyc.size() > 0) ? rd_cyc[0] : -1, t + 1);
      chk({name, "_wrcnt"}, wr_addr_q.size(), 0);
    end else begin
      model_mem[a] = d;
      chk({name, "_wrcnt"}, wr_addr_q.size(), 1);
      chk({name, "_wraddr"}, (wr_addr_q.size() > 0) ? wr_addr_q[0] : 32'hx, a);
      chk({name, "_wrdata"}, (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hx, d);
      chk({name, "_wrcyc"}, (wr_cyc.size() > 0) ? wr_cyc[0] : -1, t + 1);
      chk({name, "_rdcnt"}, rd_addr_q.size(), 0);
      chk({name, "_din_held"}, din, d);
    end
    chk({name, "_addr_held"}, addr, a);
    chk({name, "_txlen_rule"}, tx_q.size(), exp_len);
    check_resp(name, exp);
    chk({name, "_drop"}, drop_cnt, drop0);
  endtask

  typedef struct {
    logic        is_rd;
    logic [31:0] addr;
    logic [31:0] data;
    int          gap;
    int          busy;
    logic [7:0]  exp_code;
    int          exp_len;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [7:0]  b[$];
    logic [7:0]  exp[$];
    logic [31:0] a0;
    logic [7:0]  d0;
    int          t, n;
    logic        is_rd;
    logic [31:0] ra, rd;

    tbl[0] = '{1'b0, 32'h1000_0004, 32'hDEAD_BEEF, 0, 6, 8'h4B, 1};
    tbl[1] = '{1'b1, 32'h1000_0008, 32'h0,         0, 5, 8'h4B, 5};
    tbl[2] = '{1'b1, 32'h1000_0004, 32'h0,         1, 1, 8'h4B, 5};
    tbl[3] = '{1'b0, 32'h0000_0000, 32'h0000_0001, 2, 3, 8'h4B, 1};
    tbl[4] = '{1'b1, 32'h0000_0000, 32'h0,         0, 8, 8'h4B, 5};
    tbl[5] = '{1'b1, 32'hFFFF_FFFC, 32'h0,         0, 2, 8'h4B, 5};
    bus_mem[32'h1000_0008]   = 32'h1234_5678;
    model_mem[32'h1000_0008] = 32'h1234_5678;

    rst = 1'b1; rx_valid = 1'b0; rx_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_wren", wren, 1'b0);
    chk("rst_rden", rden, 1'b0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_din", din, 32'h0);
    chk("rst_busy", bridge_busy, 1'b0);
    chk("rst_drop", drop_cnt, 8'h00);

    foreach (tbl[i]) begin
      busy_len  = tbl[i].busy;
      rsp_delay = 3;
      run_frame($sformatf("tbl%0d", i), tbl[i].is_rd, tbl[i].addr, tbl[i].data, tbl[i].gap,
                tbl[i].exp_code, tbl[i].exp_len);
    end

    for (int i = 0; i < 20; i++) begin
      is_rd     = 1'($urandom_range(0, 1));
      ra        = 32'h100 + 32'($urandom_range(0, 3)) * 4;
      rd        = $urandom;
      busy_len  = $urandom_range(1, 6);
      rsp_delay = $urandom_range(1, 5);
      run_frame($sformatf("rnd%0d", i), is_rd, ra, rd, $urandom_range(0, 2), 8'h4B,
                is_rd ? 5 : 1);
    end

    // Read with the responder answering only after the timeout: error response, late data ignored.
    clear_mon();
    busy_len = 3; rsp_delay = RT + 76;
    b = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h00};
    send_bytes(b, 0, t);
    wait_idle("rdto", 3000);
    exp = '{8'h45};
    check_resp("rdto", exp);
    n = (tx_cyc.size() > 0 && rd_cyc.size() > 0) ? tx_cyc[0] - rd_cyc[0] : 0;
    chk("rdto_min_wait", n >= int'(RT), 1'b1);
    chk("rdto_max_wait", n <= int'(RT) + 4, 1'b1);
    while (cyc < t + int'(RT) + 100) @(negedge clk);
    chk("rdto_late_busy", bridge_busy, 1'b0);
    chk("rdto_late_tx", tx_q.size(), 1);

    clear_mon();
    b = '{8'h33};
    send_bytes(b, 0, t);
    wait_idle("badop", 200);
    exp = '{8'h45};
    check_resp("badop", exp);
    chk("badop_wr", wr_addr_q.size() + rd_addr_q.size(), 0);

    // Frame timeout; a byte landing on the expiry cycle must be dropped.
    clear_mon();
    a0 = addr; d0 = drop_cnt;
    b = '{8'h57, 8'hAA};
    send_bytes(b, 0, t);
    while (cyc < t + int'(FT) - 5) @(negedge clk);
    chk("fto_busy_before", bridge_busy, 1'b1);
    while (cyc < t + int'(FT)) @(negedge clk);
    rx_data = 8'h11; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("fto_busy_after", bridge_busy, 1'b0);
    chk("fto_drop", drop_cnt, d0 + 8'd1);
    chk("fto_wren", wr_addr_q.size(), 0);
    chk("fto_tx", tx_q.size(), 0);
    chk("fto_addr", addr, a0);

    // Bytes arriving while the read response is being sent.
    clear_mon();
    busy_len = 6; rsp_delay = 3; d0 = drop_cnt;
    b = '{8'h52, 8'h10, 8'h00, 8'h00, 8'h08};
    send_bytes(b, 0, t);
    n = 0;
    while (tx_q.size() == 0 && n < 200) begin @(negedge clk); n++; end
    chk("ovr_first_tx", tx_q.size() > 0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      rx_data = 8'h57; rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      @(negedge clk);
    end
    wait_idle("ovr", 500);
    exp = '{8'h4B, 8'h12, 8'h34, 8'h56, 8'h78};
    check_resp("ovr", exp);
    chk("ovr_drop", drop_cnt, d0 + 8'd3);

    // 300 drops during a read wait saturate the counter.
    clear_mon();
    rsp_delay = 0;
    b = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h00};
    send_bytes(b, 0, t);
    repeat (2) @(negedge clk);
    rx_data = 8'h5A; rx_valid = 1'b1;
    repeat (300) @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    chk("sat_drop", drop_cnt, 8'hFF);
    wait_idle("sat", 2000);
    exp = '{8'h45};
    check_resp("sat", exp);

    // Reset in the middle of a frame, then a clean write.
    clear_mon();
    b = '{8'h57, 8'h01, 8'h02};
    send_bytes(b, 0, t);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_busy", bridge_busy, 1'b0);
    chk("mrst_drop", drop_cnt, 8'h00);
    chk("mrst_addr", addr, 32'h0);
    chk("mrst_din", din, 32'h0);
    chk("mrst_strobes", {tx_valid, wren, rden}, 3'b000);
    rst = 1'b0;
    rsp_delay = 3; busy_len = 4;
    run_frame("mrst_wr", 1'b0, 32'h2000_0000, 32'hCAFE_F00D, 0, 8'h4B, 1);

    chk("tx_while_busy", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
